// File: rtl/jingle_pkg.sv
// Shared types and helpers for the feedback-jingle sequencer and its timing blocks.
package jingle_pkg;

    typedef enum logic [1:0] {
        IDLE,
        NOTE_ON,
        NOTE_GAP
    } state_t;

    typedef enum logic {
        SUCC,
        FAIL
    } mode_t;

    // Note code that drives both the piezo decoder and the LED bank dark.
    localparam int NOTE_SILENT = 0;

    // Ceiling log2 for elaboration-time sizing; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/jingle_player_tick_divider.sv
// Free-running clock divider producing a one-cycle tick every TICK_DIV clocks.
// A synchronous clear restarts the period so callers get deterministic phase.
module tick_divider
    import jingle_pkg::*;
#(
    parameter int TICK_DIV = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (clog2(TICK_DIV) < 1) ? 1 : clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_LAST);

    // Count 0..TICK_DIV-1 and wrap; clear restarts the period at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr || (cnt == CNT_LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/jingle_player.sv
// Feedback-jingle sequencer: plays an ascending success or descending fail
// note sequence on the piezo (muteable) and mirrors it on the LED bank.
module jingle_player
    import jingle_pkg::*;
#(
    parameter int TICK_DIV   = 5000000,
    parameter int ON_TICKS   = 3,
    parameter int OFF_TICKS  = 1,
    parameter int SUCC_LEN   = 3,
    parameter int FAIL_LEN   = 3,
    parameter int MAX_LEN    = 8,
    parameter int NOTE_W     = 4,
    parameter int FAIL_TOP   = 4,
    parameter int RESTART_EN = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              success,
    input  logic              fail,
    input  logic              mute,
    output logic [NOTE_W-1:0] piezo_out,
    output logic [NOTE_W-1:0] led_out,
    output logic              busy,
    output logic              done
);

    localparam int MAX_T = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int SUB_W = clog2(MAX_T) + 1;
    localparam int IDX_W = (clog2(MAX_LEN) < 1) ? 1 : clog2(MAX_LEN);

    localparam logic [SUB_W-1:0]  SUB_ON_LAST  = SUB_W'(ON_TICKS - 1);
    localparam logic [SUB_W-1:0]  SUB_OFF_LAST = SUB_W'(OFF_TICKS - 1);
    localparam logic [IDX_W-1:0]  SUCC_LAST    = IDX_W'(SUCC_LEN - 1);
    localparam logic [IDX_W-1:0]  FAIL_LAST    = IDX_W'(FAIL_LEN - 1);
    localparam logic [NOTE_W-1:0] SILENT       = NOTE_W'(NOTE_SILENT);

    state_t            state;
    mode_t             mode;
    logic [IDX_W-1:0]  idx;
    logic [SUB_W-1:0]  sub;
    logic              tick;
    logic              trig;
    logic              accept;
    mode_t             trig_mode;
    logic [IDX_W-1:0]  last_idx;
    logic [IDX_W-1:0]  idx_next;
    logic [NOTE_W-1:0] cur_note;
    logic [NOTE_W-1:0] next_note;
    logic [NOTE_W-1:0] start_note;

    // Note code for position i of the jingle in mode m; parameter limits
    // guarantee neither branch wraps.
    function automatic logic [NOTE_W-1:0] note_of(input mode_t m, input logic [IDX_W-1:0] i);
        if (m == SUCC) begin
            return NOTE_W'(i) + NOTE_W'(1);
        end
        return NOTE_W'(FAIL_TOP) - NOTE_W'(i);
    endfunction

    // Success wins when both triggers arrive together; busy triggers only
    // count when restart is enabled.
    assign trig       = success | fail;
    assign trig_mode  = success ? SUCC : FAIL;
    assign accept     = trig && ((state == IDLE) || (RESTART_EN != 0));
    assign last_idx   = (mode == SUCC) ? SUCC_LAST : FAIL_LAST;
    assign idx_next   = idx + 1'b1;
    assign cur_note   = note_of(mode, idx);
    assign next_note  = note_of(mode, idx_next);
    assign start_note = note_of(trig_mode, '0);

    // Divider restarts on every accepted trigger so note timing is fixed
    // relative to the trigger edge.
    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .tick  (tick)
    );

    // Sequencer FSM with registered piezo/LED/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mode      <= SUCC;
            idx       <= '0;
            sub       <= '0;
            piezo_out <= SILENT;
            led_out   <= SILENT;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                state     <= NOTE_ON;
                mode      <= trig_mode;
                idx       <= '0;
                sub       <= '0;
                led_out   <= start_note;
                piezo_out <= mute ? SILENT : start_note;
                busy      <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        led_out   <= SILENT;
                        piezo_out <= SILENT;
                        busy      <= 1'b0;
                    end
                    NOTE_ON: begin
                        led_out   <= cur_note;
                        piezo_out <= mute ? SILENT : cur_note;
                        if (tick) begin
                            if (sub == SUB_ON_LAST) begin
                                state     <= NOTE_GAP;
                                sub       <= '0;
                                led_out   <= SILENT;
                                piezo_out <= SILENT;
                            end else begin
                                sub <= sub + 1'b1;
                            end
                        end
                    end
                    NOTE_GAP: begin
                        led_out   <= SILENT;
                        piezo_out <= SILENT;
                        if (tick) begin
                            if (sub == SUB_OFF_LAST) begin
                                sub <= '0;
                                if (idx == last_idx) begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end else begin
                                    state     <= NOTE_ON;
                                    idx       <= idx_next;
                                    led_out   <= next_note;
                                    piezo_out <= mute ? SILENT : next_note;
                                end
                            end else begin
                                sub <= sub + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        led_out   <= SILENT;
                        piezo_out <= SILENT;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jingle_player.sv
// Directed bench for jingle_player: two instances (restart disabled/enabled)
// share stimulus; expected traces come from a hand-written cycle model.
module tb_jingle_player;

    logic       clk = 1'b0;
    logic       reset;
    logic       success;
    logic       fail;
    logic       mute;
    logic [3:0] piezo0, led0, piezo1, led1;
    logic       busy0, done0, busy1, done1;

    int total = 0;
    int bad   = 0;
    int dcount;

    always #5 clk = ~clk;

    jingle_player #(
        .TICK_DIV(4), .ON_TICKS(2), .OFF_TICKS(1), .SUCC_LEN(3), .FAIL_LEN(3),
        .MAX_LEN(8), .NOTE_W(4), .FAIL_TOP(4), .RESTART_EN(0)
    ) dut0 (
        .clk(clk), .reset(reset), .success(success), .fail(fail), .mute(mute),
        .piezo_out(piezo0), .led_out(led0), .busy(busy0), .done(done0)
    );

    jingle_player #(
        .TICK_DIV(4), .ON_TICKS(2), .OFF_TICKS(1), .SUCC_LEN(3), .FAIL_LEN(3),
        .MAX_LEN(8), .NOTE_W(4), .FAIL_TOP(4), .RESTART_EN(1)
    ) dut1 (
        .clk(clk), .reset(reset), .success(success), .fail(fail), .mute(mute),
        .piezo_out(piezo1), .led_out(led1), .busy(busy1), .done(done1)
    );

    task automatic expect_eq(input string tag, input logic [31:0] got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // Cycle k after the accepting edge (k=1 is the first busy cycle):
    // 3 notes, each 8 cycles sounding then 4 silent; done at k=37.
    function automatic int m_note(input int k, input bit fail_mode);
        int p;
        int n;
        if (k < 1 || k > 36) return 0;
        p = (k - 1) % 12;
        n = (k - 1) / 12;
        if (p >= 8) return 0;
        return fail_mode ? (4 - n) : (n + 1);
    endfunction

    function automatic int m_busy(input int k);
        return (k >= 1 && k <= 36) ? 1 : 0;
    endfunction

    function automatic int m_done(input int k);
        return (k == 37) ? 1 : 0;
    endfunction

    task automatic chk0(input string tag, input int lv, input int pv, input int bv, input int dv);
        expect_eq({tag, "/led0"}, led0, lv);
        expect_eq({tag, "/piezo0"}, piezo0, pv);
        expect_eq({tag, "/busy0"}, busy0, bv);
        expect_eq({tag, "/done0"}, done0, dv);
    endtask

    task automatic chk1(input string tag, input int lv, input int pv, input int bv, input int dv);
        expect_eq({tag, "/led1"}, led1, lv);
        expect_eq({tag, "/piezo1"}, piezo1, pv);
        expect_eq({tag, "/busy1"}, busy1, bv);
        expect_eq({tag, "/done1"}, done1, dv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        success = 1'b0;
        fail    = 1'b0;
        mute    = 1'b0;
        step();
        step();
        chk0("reset", 0, 0, 0, 0);
        chk1("reset", 0, 0, 0, 0);
        reset = 1'b0;
        step();

        // Reset mid-jingle: asynchronous, no clock edge needed.
        success = 1'b1;
        step();
        success = 1'b0;
        for (int k = 2; k <= 10; k++) step();
        expect_eq("midrst/busy0_before", busy0, 1);
        #2 reset = 1'b1;
        #1;
        chk0("midrst", 0, 0, 0, 0);
        chk1("midrst", 0, 0, 0, 0);
        #1 reset = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk0("postrst", 0, 0, 0, 0);
        chk1("postrst", 0, 0, 0, 0);

        // Success jingle, one-cycle trigger.
        success = 1'b1;
        step();
        success = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            chk0($sformatf("succ k=%0d", k), m_note(k, 0), m_note(k, 0), m_busy(k), m_done(k));
            chk1($sformatf("succ k=%0d", k), m_note(k, 0), m_note(k, 0), m_busy(k), m_done(k));
            step();
        end

        // Fail jingle with mute held: LEDs play, piezo silent.
        mute = 1'b1;
        fail = 1'b1;
        step();
        fail = 1'b0;
        dcount = 0;
        for (int k = 1; k <= 40; k++) begin
            chk0($sformatf("failmute k=%0d", k), m_note(k, 1), 0, m_busy(k), m_done(k));
            dcount += int'(done0);
            step();
        end
        expect_eq("failmute/done_count", dcount, 1);
        mute = 1'b0;

        // Both triggers at once, then fail at k=15: dut0 ignores it, dut1 restarts.
        success = 1'b1;
        fail    = 1'b1;
        step();
        success = 1'b0;
        fail    = 1'b0;
        for (int k = 1; k <= 55; k++) begin
            chk0($sformatf("prio k=%0d", k), m_note(k, 0), m_note(k, 0), m_busy(k), m_done(k));
            if (k <= 15)
                chk1($sformatf("rst1 k=%0d", k), m_note(k, 0), m_note(k, 0), m_busy(k), m_done(k));
            else
                chk1($sformatf("rst1 k=%0d", k), m_note(k - 15, 1), m_note(k - 15, 1),
                     m_busy(k - 15), m_done(k - 15));
            fail = (k == 15);
            step();
        end
        fail = 1'b0;

        // Success held high: dut0 re-triggers straight out of the done cycle,
        // dut1 restarts every cycle and stays on note 1.
        success = 1'b1;
        step();
        for (int k = 1; k <= 45; k++) begin
            if (k <= 37)
                chk0($sformatf("b2b k=%0d", k), m_note(k, 0), m_note(k, 0), m_busy(k), m_done(k));
            else
                chk0($sformatf("b2b k=%0d", k), m_note(k - 37, 0), m_note(k - 37, 0),
                     m_busy(k - 37), 0);
            chk1($sformatf("hold1 k=%0d", k), 1, 1, 1, 0);
            step();
        end
        success = 1'b0;
        for (int k = 0; k < 50; k++) step();
        chk0("final", 0, 0, 0, 0);
        chk1("final", 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jingle_player.md
Name: jingle_player

Overview:
- Parametrised feedback-jingle sequencer. Plays a short note sequence on the piezo driver and mirrors it on the LEDs when the game logic signals success or fail.
- Generalises the fixed 3-note player: configurable tick rate, note/gap lengths, jingle lengths, note width and fail-jingle pitch base.
- Adds a mute input, busy/done status and optional restart-on-retrigger.
- Sits between the game-judge logic (success/fail pulses) and the piezo tone decoder / LED bank.

Parameters:
- TICK_DIV, 5000000: clk cycles per timing tick (>=2).
- ON_TICKS, 3: ticks a note is sounded (>=1).
- OFF_TICKS, 1: ticks of silence after each note (>=1).
- SUCC_LEN, 3: notes in the success jingle (1..MAX_LEN).
- FAIL_LEN, 3: notes in the fail jingle (1..MAX_LEN).
- MAX_LEN, 8: upper bound on jingle length; sizes the note index.
- NOTE_W, 4: width of the note code; 0 means silence.
- FAIL_TOP, 4: first fail note; must satisfy FAIL_TOP >= FAIL_LEN and FAIL_TOP < 2**NOTE_W.
- RESTART_EN, 0: 1 means a trigger while busy restarts playback; 0 means it is ignored.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- success  in  1  synchronous trigger, level sampled each clk
- fail  in  1  synchronous trigger, level sampled each clk
- mute  in  1  1 forces piezo_out to 0; LEDs unaffected
- piezo_out  out  NOTE_W  note code to tone decoder, 0 = silent
- led_out  out  NOTE_W  note code to LED bank; always equals the unmuted note
- busy  out  1  high while a jingle is playing
- done  out  1  one-cycle pulse when a jingle completes (not on abort/restart)

Behaviour:
- Reset (async, any time, including mid-jingle): state=IDLE, tick counter=0, note index=0, piezo_out=0, led_out=0, busy=0, done=0. Outputs are registered.
- Tick divider: counts 0..TICK_DIV-1 and wraps. tick=1 in the cycle the count equals TICK_DIV-1. The divider is cleared to 0 on every accepted trigger so jingle timing is deterministic.
- Trigger accept:
  - In IDLE, success or fail high at a clk edge is accepted.
  - Both high together: success wins. The mode (SUCC or FAIL) is latched.
  - While busy with RESTART_EN=0: triggers are ignored.
  - While busy with RESTART_EN=1: a trigger restarts from note 0 with the new mode; no done pulse for the aborted jingle.
  - A level held high re-triggers only after the jingle has finished (IDLE samples it again). The driver supplies pulses.
- Note values for index i:
  - SUCC: i+1 (ascending 1,2,3...).
  - FAIL: FAIL_TOP-i (descending 4,3,2...).
  - Arithmetic is unsigned NOTE_W; parameter checks guarantee no wrap.
- FSM states:
  - IDLE: outputs 0, busy=0. On accept -> NOTE_ON, index=0.
  - NOTE_ON: led_out = note(index); piezo_out = mute ? 0 : note(index); busy=1. After ON_TICKS ticks -> NOTE_GAP.
  - NOTE_GAP: outputs 0, busy=1. After OFF_TICKS ticks: if index == LEN-1 -> IDLE and done=1 for 1 cycle; else index+1 -> NOTE_ON.
  - A tick sub-counter (width clog2(max(ON_TICKS,OFF_TICKS))+1) counts ticks within a state and clears on each state change.
- Latency and duration:
  - Accept at edge t: note 0 visible and busy=1 from cycle t+1.
  - Each note occupies ON_TICKS*TICK_DIV cycles on, then OFF_TICKS*TICK_DIV cycles silent.
  - Total busy = LEN*(ON_TICKS+OFF_TICKS)*TICK_DIV cycles.
  - done is high in the first IDLE cycle, simultaneous with busy falling; an IDLE trigger in that same cycle is accepted.
- mute is combinational into the piezo output register path only. Toggling mute mid-note takes effect on the next cycle and does not alter timing.

Decomposition:
- Shared package jingle_pkg: state enum (IDLE, NOTE_ON, NOTE_GAP), mode enum (SUCC, FAIL), NOTE_SILENT=0 constant, clog2 helper.
- One sub-module, tick_divider (param TICK_DIV; inputs clk, reset, clr; output tick), reusable by other timed game blocks.
- Note generation and the FSM stay in jingle_player.

Test Plan (TICK_DIV=4, ON_TICKS=2, OFF_TICKS=1, LEN=3, FAIL_TOP=4):
- Reset mid-jingle: success pulse, then reset at cycle 10 -> all outputs 0 immediately; after release, idle and busy=0 until the next trigger.
- Success jingle: 1-cycle success at t -> led_out 1 for cycles t+1..t+8, 0 for 4 cycles, then 2, then 3; busy falls and done=1 at t+37.
- Fail with mute: fail pulse, mute=1 throughout -> led_out 4,3,2 with the same timing, piezo_out stays 0, done pulses once.
- Priority and ignore: success and fail high together -> success jingle. A fail pulse at t+15 with RESTART_EN=0 -> no change; done at t+37.
- Restart: RESTART_EN=1, success at t, fail at t+15 -> led_out=4 at t+16, no done at t+37, done at t+52.
- Back-to-back: success held high continuously -> first jingle done at t+37, next jingle note 1 starting at t+38.
